// File: rtl/ad_pingpong_writer.sv
// Write-side initiator for the ping-pong SRAM pair: turns AD samples into SRAM write
// cycles on the CH2 channel and swaps buffers once one is full and the reader is done.
module ad_pingpong_writer #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int WE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_valid,
    output logic              ad_ready,
    input  logic              rd_done,
    output logic [ADDR_W-1:0] addr_CH2,
    output logic [DATA_W-1:0] data_CH2,
    output logic              ce_CH2,
    output logic              oe_CH2,
    output logic              we_CH2,
    output logic              sram_flag,
    output logic              swap,
    output logic              overflow
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        WAIT_SWAP
    } state_t;

    localparam int WCW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [WCW-1:0]    WE_LAST   = WCW'(WE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t r_state;
    state_t w_next;

    logic [WCW-1:0]    r_weCnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_flag;
    logic              r_rdFree;
    logic              r_ovf;

    logic w_ready;
    logic w_accept;
    logic w_swap;
    logic w_ce;
    logic w_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = SETUP;
            SETUP:     w_next = WRITE;
            WRITE:     if (r_weCnt == WE_LAST) w_next = HOLD;
            HOLD:      w_next = (r_addr == ADDR_LAST) ? WAIT_SWAP : IDLE;
            WAIT_SWAP: if (r_rdFree) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // ad_ready and swap are gated by rst so both read 0 while reset is held.
    always_comb begin
        w_ready = 1'b0;
        w_ce    = 1'b1;
        w_we    = 1'b1;
        w_swap  = 1'b0;
        case (r_state)
            IDLE:        w_ready = en & ~rst;
            SETUP, HOLD: w_ce = 1'b0;
            WRITE: begin
                w_ce = 1'b0;
                w_we = 1'b0;
            end
            WAIT_SWAP:   w_swap = r_rdFree & ~rst;
            default:     ;
        endcase
    end

    assign w_accept = ad_valid & w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_weCnt  <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_flag   <= 1'b0;
            r_rdFree <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= ad_data;
            end

            if (r_state == WRITE) begin
                r_weCnt <= r_weCnt + WCW'(1);
            end else begin
                r_weCnt <= '0;
            end

            if (w_swap) begin
                r_addr <= '0;
                r_flag <= ~r_flag;
            end else if (r_state == HOLD && r_addr != ADDR_LAST) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            // A release pulse landing in the swap cycle must not be lost.
            if (rd_done) begin
                r_rdFree <= 1'b1;
            end else if (w_swap) begin
                r_rdFree <= 1'b0;
            end

            if (ad_valid && !w_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ad_ready  = w_ready;
    assign addr_CH2  = r_addr;
    assign data_CH2  = r_data;
    assign ce_CH2    = w_ce;
    assign oe_CH2    = 1'b1;
    assign we_CH2    = w_we;
    assign sram_flag = r_flag;
    assign swap      = w_swap;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_ad_pingpong_writer.sv
// Bench for ad_pingpong_writer: directed scenarios plus random traffic, every cycle
// compared against a timeline model of write transactions and buffer swaps.
module tb_ad_pingpong_writer;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 4;
    localparam int WE_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] ad_data;
    logic              ad_valid;
    logic              ad_ready;
    logic              rd_done;
    logic [ADDR_W-1:0] addr_CH2;
    logic [DATA_W-1:0] data_CH2;
    logic              ce_CH2;
    logic              oe_CH2;
    logic              we_CH2;
    logic              sram_flag;
    logic              swap;
    logic              overflow;

    always #5 clk = ~clk;

    ad_pingpong_writer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .WE_CYCLES(WE_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ad_data  (ad_data),
        .ad_valid (ad_valid),
        .ad_ready (ad_ready),
        .rd_done  (rd_done),
        .addr_CH2 (addr_CH2),
        .data_CH2 (data_CH2),
        .ce_CH2   (ce_CH2),
        .oe_CH2   (oe_CH2),
        .we_CH2   (we_CH2),
        .sram_flag(sram_flag),
        .swap     (swap),
        .overflow (overflow)
    );

    int errors = 0;
    int checks = 0;
    int weLow  = 0;

    // Model: mK is the clock index within a write transaction (0 = no write in flight).
    int              mK;
    int              mFill;
    logic            mFlag;
    logic            mRdFree;
    logic            mOvf;
    logic            mWait;
    logic [DATA_W-1:0] mData;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mK      = 0;
        mFill   = 0;
        mFlag   = 1'b0;
        mRdFree = 1'b1;
        mOvf    = 1'b0;
        mWait   = 1'b0;
        mData   = '0;
    endtask

    function automatic logic modelReady(input logic r, input logic e);
        return !r && e && (mK == 0) && !mWait;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [DATA_W-1:0] d, input logic rd);
        logic expReady;
        logic doSwap;
        rst      = r;
        en       = e;
        ad_valid = v;
        ad_data  = d;
        rd_done  = rd;
        @(negedge clk);
        expReady = modelReady(r, e);
        doSwap   = !r && mWait && mRdFree;
        if (we_CH2 === 1'b0) weLow++;
        checkOutput("ad_ready",  32'(ad_ready),  32'(expReady));
        checkOutput("ce_CH2",    32'(ce_CH2),    32'(mK == 0));
        checkOutput("we_CH2",    32'(we_CH2),    32'(!(mK >= 2 && mK <= WE_CYCLES + 1)));
        checkOutput("oe_CH2",    32'(oe_CH2),    32'd1);
        checkOutput("addr_CH2",  32'(addr_CH2),  32'(mFill));
        checkOutput("data_CH2",  32'(data_CH2),  32'(mData));
        checkOutput("sram_flag", 32'(sram_flag), 32'(mFlag));
        checkOutput("swap",      32'(swap),      32'(doSwap));
        checkOutput("overflow",  32'(overflow),  32'(mOvf));
        @(posedge clk);
        if (r) begin
            modelReset();
        end else begin
            if (v && !expReady) mOvf = 1'b1;
            if (mK > 0) begin
                if (mK == WE_CYCLES + 2) begin
                    mK = 0;
                    if (mFill == DEPTH - 1) mWait = 1'b1;
                    else mFill++;
                end else begin
                    mK++;
                end
            end else if (v && expReady) begin
                mData = d;
                mK    = 1;
            end
            if (doSwap) begin
                mWait = 1'b0;
                mFill = 0;
                mFlag = ~mFlag;
            end
            if (rd) mRdFree = 1'b1;
            else if (doSwap) mRdFree = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic pushSample(input logic [DATA_W-1:0] d);
        for (int i = 0; i < 50 && !modelReady(1'b0, 1'b1); i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, d, 1'b0);
    endtask

    initial begin
        logic r, e, v, rd;
        rst      = 1'b1;
        en       = 1'b0;
        ad_valid = 1'b0;
        ad_data  = '0;
        rd_done  = 1'b0;
        modelReset();
        @(posedge clk);
        #1;

        // Reset held two clocks with a sample offered.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);

        // Single write and its timing.
        pushSample(16'h1234);
        checkOutput("t2_data", 32'(data_CH2), 32'h1234);
        checkOutput("t2_addr0", 32'(addr_CH2), 32'd0);
        idle(4);
        checkOutput("t2_addr1", 32'(addr_CH2), 32'd1);

        // Fill the first buffer; reader starts free so the swap is immediate.
        pushSample(16'hA002);
        pushSample(16'hA003);
        pushSample(16'hA004);
        idle(5);
        checkOutput("t3_flag", 32'(sram_flag), 32'd1);
        checkOutput("t3_addr", 32'(addr_CH2), 32'd0);

        // Fill again without a release: the swap must wait.
        pushSample(16'hB001);
        pushSample(16'hB002);
        pushSample(16'hB003);
        pushSample(16'hB004);
        idle(8);
        checkOutput("t4_ready", 32'(ad_ready), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0);
        checkOutput("t4_ovf", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        // Release pulse coincident with the swap cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("t4_flag", 32'(sram_flag), 32'd0);

        // Release was kept, so the next full buffer swaps with no wait, even with en low.
        pushSample(16'hC001);
        pushSample(16'hC002);
        pushSample(16'hC003);
        pushSample(16'hC004);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("t5_flag", 32'(sram_flag), 32'd1);

        // Reset in the middle of the strobe.
        pushSample(16'hD001);
        idle(1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("t6_we", 32'(we_CH2), 32'd1);
        checkOutput("t6_ce", 32'(ce_CH2), 32'd1);
        checkOutput("t6_addr", 32'(addr_CH2), 32'd0);
        checkOutput("t6_flag", 32'(sram_flag), 32'd0);

        // Enable dropped during SETUP: the write still completes.
        idle(1);
        weLow = 0;
        pushSample(16'hE001);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("t6_weLow", 32'(weLow), 32'(WE_CYCLES));
        checkOutput("t6_ready", 32'(ad_ready), 32'd0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            rd = ($urandom_range(0, 19) == 0);
            if (modelReady(r, e)) v = $urandom_range(0, 1) == 1;
            else v = ($urandom_range(0, 29) == 0);
            applyStimulus(r, e, v, DATA_W'($urandom), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
